// File: rtl/hm01b0_i2c_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hm01b0_i2c_pkg
// Purpose  : Shared widths, responder address and state encoding for the
//            HM01B0 I2C register-write responder.
// Revision : 1.0  initial release
// ============================================================================
package hm01b0_i2c_pkg;

    localparam int BYTE_W = 8;
    localparam int ADDR_W = 16;
    localparam int CNT_W  = 4;

    localparam logic [6:0] HM01B0_DEV_ADDR = 7'h24;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_DEV     = 4'd1,
        ST_ACK_DEV = 4'd2,
        ST_AH      = 4'd3,
        ST_ACK_AH  = 4'd4,
        ST_AL      = 4'd5,
        ST_ACK_AL  = 4'd6,
        ST_WD      = 4'd7,
        ST_ACK_WD  = 4'd8,
        ST_RD      = 4'd9,
        ST_MACK    = 4'd10,
        ST_IGNORE  = 4'd11
    } state_t;

    // Receive state that follows each ACK slot of a write transaction.
    function automatic state_t ack_next(input state_t s);
        case (s)
            ST_ACK_DEV: return ST_AH;
            ST_ACK_AH:  return ST_AL;
            ST_ACK_AL:  return ST_WD;
            ST_ACK_WD:  return ST_WD;
            default:    return ST_IDLE;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/hm01b0_i2c_responder_bus_sampler.sv
`default_nettype none
// ============================================================================
// Module   : i2c_bus_sampler
// Purpose  : Synchronises raw SCL/SDA pads and decodes registered one-cycle
//            SCL rise/fall, START and STOP pulses plus the sampled SDA level.
//            Pad-to-pulse latency is three clocks.
// Revision : 1.0  initial release
// ============================================================================
module i2c_bus_sampler (
    input  logic clock,
    input  logic reset,
    input  logic scl_in,
    input  logic sda_in,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop,
    output logic sda_bit
);

    logic r_scl_meta, r_scl_sync, r_scl_hist;
    logic r_sda_meta, r_sda_sync, r_sda_hist;
    logic r_scl_rise, r_scl_fall, r_start, r_stop, r_sda_bit;

    // Two-flop synchronisers, history flops and registered edge decode;
    // reset to the idle bus level so no false START/STOP follows reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_scl_meta <= 1'b1;
            r_scl_sync <= 1'b1;
            r_scl_hist <= 1'b1;
            r_sda_meta <= 1'b1;
            r_sda_sync <= 1'b1;
            r_sda_hist <= 1'b1;
            r_scl_rise <= 1'b0;
            r_scl_fall <= 1'b0;
            r_start    <= 1'b0;
            r_stop     <= 1'b0;
            r_sda_bit  <= 1'b1;
        end else begin
            r_scl_meta <= scl_in;
            r_scl_sync <= r_scl_meta;
            r_scl_hist <= r_scl_sync;
            r_sda_meta <= sda_in;
            r_sda_sync <= r_sda_meta;
            r_sda_hist <= r_sda_sync;
            r_scl_rise <= r_scl_sync & ~r_scl_hist;
            r_scl_fall <= ~r_scl_sync & r_scl_hist;
            r_start    <= r_scl_sync & r_scl_hist & r_sda_hist & ~r_sda_sync;
            r_stop     <= r_scl_sync & r_scl_hist & ~r_sda_hist & r_sda_sync;
            r_sda_bit  <= r_sda_sync;
        end
    end

    assign scl_rise = r_scl_rise;
    assign scl_fall = r_scl_fall;
    assign start    = r_start;
    assign stop     = r_stop;
    assign sda_bit  = r_sda_bit;

endmodule
`default_nettype wire

// File: rtl/hm01b0_i2c_responder.sv
`default_nettype none
// ============================================================================
// Module   : hm01b0_i2c_responder
// Purpose  : I2C target modelling the HM01B0 register interface. Decodes
//            device address, 16-bit register pointer and data bytes and
//            emits one write strobe per data byte.
//            Optional macro HM01B0_I2C_READ_EN adds register reads served
//            from an external lookup (rd_req / rd_addr / rd_data).
// Revision : 1.0  initial release
// ============================================================================
module hm01b0_i2c_responder
    import hm01b0_i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = HM01B0_DEV_ADDR
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              scl_in,
    input  logic              sda_in,
    output logic              sda_oe,
    output logic              wr_valid,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [BYTE_W-1:0] wr_data,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [BYTE_W-1:0] rd_data,
    output logic              busy
);

    localparam logic [CNT_W-1:0]  c_last_bit = CNT_W'(BYTE_W - 1);
    localparam logic [CNT_W-1:0]  c_one      = CNT_W'(1);
    localparam logic [ADDR_W-1:0] c_inc      = ADDR_W'(1);

    logic w_scl_rise, w_scl_fall, w_start, w_stop, w_sda_bit;

    i2c_bus_sampler u_sampler (
        .clock    (clock),
        .reset    (reset),
        .scl_in   (scl_in),
        .sda_in   (sda_in),
        .scl_rise (w_scl_rise),
        .scl_fall (w_scl_fall),
        .start    (w_start),
        .stop     (w_stop),
        .sda_bit  (w_sda_bit)
    );

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [BYTE_W-1:0] r_shift;
    logic [BYTE_W-1:0] r_addr_hi;
    logic [ADDR_W-1:0] r_ptr;
    logic              r_ack_on;
    logic              r_sda_oe;
    logic              r_wr_valid;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [BYTE_W-1:0] r_wr_data;
    logic              r_busy;
    logic [BYTE_W-1:0] w_shift_nx;
    logic              w_dev_match;

`ifdef HM01B0_I2C_READ_EN
    logic              r_rd_mode;
    logic              r_rd_req;
    logic              r_rd_ld;
    logic [ADDR_W-1:0] r_rd_addr;

    assign rd_req  = r_rd_req;
    assign rd_addr = r_rd_addr;
`else
    logic w_unused_rd_data;

    assign rd_req           = 1'b0;
    assign rd_addr          = '0;
    assign w_unused_rd_data = ^rd_data;
`endif

    assign w_shift_nx  = {r_shift[BYTE_W-2:0], w_sda_bit};
    assign w_dev_match = (w_shift_nx[BYTE_W-1:1] == DEV_ADDR);

    // Protocol FSM: STOP/START take priority over bit events, then each
    // state reacts to decoded SCL edges; all outputs are registered here.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_shift    <= '0;
            r_addr_hi  <= '0;
            r_ptr      <= '0;
            r_ack_on   <= 1'b0;
            r_sda_oe   <= 1'b0;
            r_wr_valid <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_busy     <= 1'b0;
`ifdef HM01B0_I2C_READ_EN
            r_rd_mode  <= 1'b0;
            r_rd_req   <= 1'b0;
            r_rd_ld    <= 1'b0;
            r_rd_addr  <= '0;
`endif
        end else begin
            r_wr_valid <= 1'b0;
`ifdef HM01B0_I2C_READ_EN
            r_rd_req   <= 1'b0;
            r_rd_ld    <= r_rd_req;
`endif
            if (w_stop) begin
                r_state  <= ST_IDLE;
                r_sda_oe <= 1'b0;
                r_busy   <= 1'b0;
                r_cnt    <= '0;
                r_ack_on <= 1'b0;
            end else if (w_start) begin
                // Repeated START keeps the register pointer for reads.
                r_state  <= ST_DEV;
                r_sda_oe <= 1'b0;
                r_busy   <= 1'b1;
                r_cnt    <= '0;
                r_ack_on <= 1'b0;
            end else begin
                case (r_state)
                    ST_DEV, ST_AH, ST_AL, ST_WD: begin
                        if (w_scl_rise) begin
                            r_shift <= w_shift_nx;
                            r_cnt   <= r_cnt + c_one;
                            if (r_cnt == c_last_bit) begin
                                r_cnt <= '0;
                                case (r_state)
                                    ST_DEV: begin
                                        if (w_dev_match && !w_shift_nx[0]) begin
                                            r_state <= ST_ACK_DEV;
`ifdef HM01B0_I2C_READ_EN
                                            r_rd_mode <= 1'b0;
                                        end else if (w_dev_match) begin
                                            r_state   <= ST_ACK_DEV;
                                            r_rd_mode <= 1'b1;
`endif
                                        end else begin
                                            r_state <= ST_IGNORE;
                                        end
                                    end
                                    ST_AH: begin
                                        r_addr_hi <= w_shift_nx;
                                        r_state   <= ST_ACK_AH;
                                    end
                                    ST_AL: begin
                                        r_ptr   <= {r_addr_hi, w_shift_nx};
                                        r_state <= ST_ACK_AL;
                                    end
                                    default: begin
                                        r_wr_valid <= 1'b1;
                                        r_wr_addr  <= r_ptr;
                                        r_wr_data  <= w_shift_nx;
                                        r_ptr      <= r_ptr + c_inc;
                                        r_state    <= ST_ACK_WD;
                                    end
                                endcase
                            end
                        end
                    end
                    ST_ACK_DEV, ST_ACK_AH, ST_ACK_AL, ST_ACK_WD: begin
                        // First fall pulls SDA low, second fall releases it.
                        if (w_scl_fall) begin
                            if (!r_ack_on) begin
                                r_ack_on <= 1'b1;
                                r_sda_oe <= 1'b1;
                            end else begin
                                r_ack_on <= 1'b0;
                                r_sda_oe <= 1'b0;
                                r_cnt    <= '0;
                                r_state  <= ack_next(r_state);
`ifdef HM01B0_I2C_READ_EN
                                if (r_state == ST_ACK_DEV && r_rd_mode) begin
                                    r_state   <= ST_RD;
                                    r_rd_req  <= 1'b1;
                                    r_rd_addr <= r_ptr;
                                end
`endif
                            end
                        end
                    end
`ifdef HM01B0_I2C_READ_EN
                    ST_RD: begin
                        // Lookup data arrives two clocks after the request.
                        if (r_rd_ld) begin
                            r_shift  <= rd_data;
                            r_sda_oe <= ~rd_data[BYTE_W-1];
                        end else if (w_scl_rise) begin
                            r_cnt <= r_cnt + c_one;
                        end else if (w_scl_fall) begin
                            if (r_cnt == CNT_W'(BYTE_W)) begin
                                r_sda_oe <= 1'b0;
                                r_cnt    <= '0;
                                r_state  <= ST_MACK;
                            end else begin
                                r_shift  <= {r_shift[BYTE_W-2:0], 1'b0};
                                r_sda_oe <= ~r_shift[BYTE_W-2];
                            end
                        end
                    end
                    ST_MACK: begin
                        // NACK ends the read; a fall here means it was ACKed.
                        if (w_scl_rise) begin
                            if (w_sda_bit) begin
                                r_state <= ST_IGNORE;
                            end
                        end else if (w_scl_fall) begin
                            r_ptr     <= r_ptr + c_inc;
                            r_rd_addr <= r_ptr + c_inc;
                            r_rd_req  <= 1'b1;
                            r_cnt     <= '0;
                            r_state   <= ST_RD;
                        end
                    end
`endif
                    default: begin
                    end
                endcase
            end
        end
    end

    assign sda_oe   = r_sda_oe;
    assign wr_valid = r_wr_valid;
    assign wr_addr  = r_wr_addr;
    assign wr_data  = r_wr_data;
    assign busy     = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_hm01b0_i2c_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_hm01b0_i2c_responder
// Purpose  : Self-checking bench: an I2C initiator drives directed and
//            random write transactions; a transaction-level model predicts
//            ACKs and register-write strobes, and a per-cycle monitor checks
//            strobes, held outputs and bus release.
// Revision : 1.0  initial release
// ============================================================================
module tb_hm01b0_i2c_responder;

    localparam int Q = 6;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        scl = 1'b1;
    logic        sda_m = 1'b1;
    logic [7:0]  rd_data = 8'h00;
    logic        sda_line;
    logic        sda_oe, wr_valid, rd_req, busy;
    logic [15:0] wr_addr, rd_addr;
    logic [7:0]  wr_data;

    assign sda_line = sda_m & ~sda_oe;

    always #5 clock = ~clock;

    hm01b0_i2c_responder dut (
        .clock    (clock),
        .reset    (reset),
        .scl_in   (scl),
        .sda_in   (sda_line),
        .sda_oe   (sda_oe),
        .wr_valid (wr_valid),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_req   (rd_req),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .busy     (busy)
    );

    int          n_chk = 0;
    int          n_pass = 0;
    bit          mon_en = 0;
    bit          quiet = 0;
    bit          bus_active = 0;
    logic [15:0] m_ptr = 16'h0000;
    logic [7:0]  m_hi = 8'h00;
    logic [15:0] hold_addr = 16'h0000;
    logic [7:0]  hold_data = 8'h00;
    logic [23:0] exp_wr_q[$];
    logic [23:0] act_log[$];
    logic [15:0] exp_rd_q[$];
    logic [7:0]  tx_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    function automatic logic [7:0] lookup(input logic [15:0] a);
        return (a == 16'h3000) ? 8'hC3 : (a[7:0] ^ 8'h5A);
    endfunction

    // External register lookup: answers the cycle after a request.
    initial begin
        forever begin
            @(negedge clock);
            if (rd_req) rd_data = lookup(rd_addr);
        end
    end

    // Per-cycle comparison of DUT outputs against the transaction model.
    always @(negedge clock) begin
        if (mon_en && !reset) begin
            if (wr_valid) begin
                act_log.push_back({wr_addr, wr_data});
                chk("wr_expected", 32'(exp_wr_q.size() != 0), 1);
                if (exp_wr_q.size() != 0) begin
                    logic [23:0] e;
                    e = exp_wr_q.pop_front();
                    chk("wr_addr", wr_addr, e[23:8]);
                    chk("wr_data", wr_data, e[7:0]);
                    hold_addr = e[23:8];
                    hold_data = e[7:0];
                end
            end else begin
                chk("wr_addr_hold", wr_addr, hold_addr);
                chk("wr_data_hold", wr_data, hold_data);
            end
            if (quiet) chk("oe_quiet", sda_oe, 0);
`ifdef HM01B0_I2C_READ_EN
            if (rd_req) begin
                chk("rd_expected", 32'(exp_rd_q.size() != 0), 1);
                if (exp_rd_q.size() != 0) chk("rd_addr", rd_addr, exp_rd_q.pop_front());
            end
`else
            chk("rd_req_tied", rd_req, 0);
            chk("rd_addr_tied", rd_addr, 0);
`endif
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic bit_x(input logic b, output logic s);
        sda_m = b;
        wait_clk(Q);
        scl = 1'b1;
        wait_clk(Q);
        s = sda_line;
        wait_clk(Q);
        scl = 1'b0;
        wait_clk(Q);
    endtask

    task automatic start_c();
        sda_m = 1'b0;
        wait_clk(2 * Q);
        scl = 1'b0;
        wait_clk(Q);
    endtask

    task automatic rstart_c();
        sda_m = 1'b1;
        wait_clk(Q);
        scl = 1'b1;
        wait_clk(2 * Q);
        sda_m = 1'b0;
        wait_clk(2 * Q);
        scl = 1'b0;
        wait_clk(Q);
    endtask

    task automatic stop_c();
        sda_m = 1'b0;
        wait_clk(Q);
        scl = 1'b1;
        wait_clk(2 * Q);
        sda_m = 1'b1;
        wait_clk(2 * Q);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bit_x(b[i], s);
        bit_x(1'b1, ack);
    endtask

    task automatic read_byte(output logic [7:0] v, input logic mack);
        logic s;
        v = 8'h00;
        for (int i = 0; i < 8; i++) begin
            bit_x(1'b1, s);
            v = {v[6:0], s};
        end
        bit_x(mack, s);
    endtask

    // Write transaction: device byte then tx_q (AH, AL, data...), optional
    // partial trailing byte, ending in STOP or left open for a repeated START.
    task automatic do_write(input logic [7:0] dev, input int part, input bit end_rs);
        logic a, s;
        bit   match;
        match = (dev == 8'h48);
        quiet = !match;
        if (bus_active) rstart_c(); else start_c();
        chk("busy_start", busy, 1);
        send_byte(dev, a);
        chk("ack_dev", a, !match);
        foreach (tx_q[i]) begin
            if (match) begin
                if (i == 0) m_hi = tx_q[i];
                else if (i == 1) m_ptr = {m_hi, tx_q[i]};
                else begin
                    exp_wr_q.push_back({m_ptr, tx_q[i]});
                    m_ptr = m_ptr + 16'd1;
                end
            end
            send_byte(tx_q[i], a);
            chk("ack_byte", a, !match);
            if (match && i >= 2) chk("wr_done", exp_wr_q.size(), 0);
        end
        for (int k = 0; k < part; k++) bit_x(1'($urandom_range(0, 1)), s);
        if (part > 0 || !end_rs) begin
            stop_c();
            bus_active = 0;
            chk("busy_stop", busy, 0);
            chk("wr_none_left", exp_wr_q.size(), 0);
        end else begin
            bus_active = 1;
        end
        quiet = 0;
    endtask

`ifdef HM01B0_I2C_READ_EN
    task automatic read_test();
        logic       a;
        logic [7:0] v;
        start_c();
        send_byte(8'h48, a); chk("rd_ack_dev_w", a, 0);
        send_byte(8'h30, a); chk("rd_ack_ah", a, 0);
        send_byte(8'h00, a); chk("rd_ack_al", a, 0);
        m_ptr = 16'h3000;
        exp_rd_q.push_back(16'h3000);
        exp_rd_q.push_back(16'h3001);
        rstart_c();
        send_byte(8'h49, a); chk("rd_ack_dev_r", a, 0);
        read_byte(v, 1'b0);
        chk("rd_byte0", v, 8'hC3);
        read_byte(v, 1'b1);
        chk("rd_byte1", v, 8'h5B);
        chk("rd_release", sda_oe, 0);
        stop_c();
        chk("rd_busy_stop", busy, 0);
        chk("rd_all_req", exp_rd_q.size(), 0);
    endtask
`endif

    task automatic reset_mid_ack();
        logic       s;
        logic [7:0] d;
        d = 8'h48;
        start_c();
        for (int i = 7; i >= 0; i--) bit_x(d[i], s);
        @(negedge clock);
        chk("oe_in_ack", sda_oe, 1);
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk("oe_after_reset", sda_oe, 0);
        hold_addr = 16'h0000;
        hold_data = 8'h00;
        exp_wr_q.delete();
        m_ptr = 16'h0000;
        @(negedge clock);
        reset = 1'b0;
        stop_c();
        bus_active = 0;
        chk("busy_after_reset", busy, 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        repeat (4) @(negedge clock);
        chk("rst_sda_oe", sda_oe, 0);
        chk("rst_wr_valid", wr_valid, 0);
        chk("rst_rd_req", rd_req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_rd_addr", rd_addr, 0);
        reset = 1'b0;
        mon_en = 1;
        wait_clk(8);

        // Single-byte write to 0x0100.
        act_log.delete();
        tx_q = '{8'h01, 8'h00, 8'h01};
        do_write(8'h48, 0, 0);
        chk("t1_count", act_log.size(), 1);
        if (act_log.size() >= 1) chk("t1_strobe", act_log[0], 24'h010001);

        // Pointer wrap from 0xFFFF to 0x0000.
        act_log.delete();
        tx_q = '{8'hFF, 8'hFF, 8'hAA, 8'h55};
        do_write(8'h48, 0, 0);
        chk("t2_count", act_log.size(), 2);
        if (act_log.size() >= 2) begin
            chk("t2_strobe0", act_log[0], 24'hFFFFAA);
            chk("t2_strobe1", act_log[1], 24'h000055);
        end

        // Foreign address (7-bit 0x50) is NACKed and ignored.
        act_log.delete();
        tx_q = '{8'h12, 8'h34, 8'h56};
        do_write(8'hA0, 0, 0);
        chk("t3_count", act_log.size(), 0);

        // STOP after four data bits discards the partial byte.
        act_log.delete();
        tx_q = '{8'h00, 8'h10};
        do_write(8'h48, 4, 0);
        chk("t4_count", act_log.size(), 0);

        // Reset while ACK is driven, then a normal write.
        reset_mid_ack();
        act_log.delete();
        tx_q = '{8'h12, 8'h34, 8'h56};
        do_write(8'h48, 0, 0);
        chk("t5_count", act_log.size(), 1);
        if (act_log.size() >= 1) chk("t5_strobe", act_log[0], 24'h123456);

`ifdef HM01B0_I2C_READ_EN
        read_test();
`else
        tx_q.delete();
        do_write(8'h49, 0, 0);
`endif

        for (int t = 0; t < 30; t++) begin
            int         n;
            int         part;
            logic [7:0] dev;
            bit         rs;
            n = $urandom_range(0, 5);
            tx_q.delete();
            for (int i = 0; i < n; i++) tx_q.push_back(8'($urandom_range(0, 255)));
            if (n >= 2 && $urandom_range(0, 2) == 0) begin
                tx_q[0] = 8'hFF;
                tx_q[1] = 8'($urandom_range(252, 255));
            end
            dev = 8'h48;
            if ($urandom_range(0, 4) == 0) begin
                dev = 8'($urandom_range(0, 255));
                if (dev[7:1] == 7'h24) dev = 8'hA0;
            end
            part = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : 0;
            rs = ($urandom_range(0, 3) == 0);
            do_write(dev, part, rs);
        end
        if (bus_active) begin
            stop_c();
            bus_active = 0;
            chk("final_busy", busy, 0);
        end
        chk("final_wr_queue", exp_wr_q.size(), 0);

        wait_clk(4);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
